// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU execution path.
//   aluop_t     - 4-bit operation code driven by the controller on aluop
//   alu_state_t - state of the iterative ALU sequencer (visible on dbg_state)
//   XLEN_DEF    - default operand/result width
//   is_shift()  - true for SLL/SRL/SRA, the ops that iterate one bit per cycle
package alu_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_SLT  = 4'b0011,
        OP_SLTU = 4'b0100,
        OP_XOR  = 4'b0101,
        OP_SLL  = 4'b0110,
        OP_SRL  = 4'b0111,
        OP_SRA  = 4'b1000,
        OP_OR   = 4'b1001,
        OP_AND  = 4'b1010
    } aluop_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } alu_state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_single_cycle.sv
// alu_single_cycle: combinational ADD/SUB/SLT/SLTU/XOR/OR/AND.
//   i_op     - operation code; shifts and undefined codes yield 0
//   i_opa    - first operand (rs1)
//   i_opb    - second operand (rs2)
//   o_result - result, valid in the same cycle
module alu_single_cycle
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [3:0]      i_op,
    input  logic [XLEN-1:0] i_opa,
    input  logic [XLEN-1:0] i_opb,
    output logic [XLEN-1:0] o_result
);

    always_comb begin
        o_result = '0;
        case (i_op)
            OP_ADD:  o_result = i_opa + i_opb;
            OP_SUB:  o_result = i_opa - i_opb;
            OP_SLT:  o_result = {{(XLEN-1){1'b0}}, ($signed(i_opa) < $signed(i_opb))};
            OP_SLTU: o_result = {{(XLEN-1){1'b0}}, (i_opa < i_opb)};
            OP_XOR:  o_result = i_opa ^ i_opb;
            OP_OR:   o_result = i_opa | i_opb;
            OP_AND:  o_result = i_opa & i_opb;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_iterative.sv
// alu_iterative: R-type execution unit. Single-cycle logic/arith/compare ops,
// shifts iterate one bit per cycle. Result is returned with rd and a
// register-file write enable.
//   clk, rst            - clock; asynchronous active-high reset
//   in_valid / in_ready - request handshake
//   aluop, rf_en, rd    - decoded op, writeback enable, destination register
//   opa, opb            - operands; shift amount is opb[SHAMT_W-1:0]
//   out_valid/out_ready - result handshake
//   out_result, out_rd, out_we - registered result, rd, rf_en && rd != 0
//   busy                - sequencer not idle
//   dbg_state           - current sequencer state
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A producer holds valid and its payload stable until that edge;
// ready may depend combinationally on the consumer's own ready (in_ready
// follows out_ready while a result is waiting, enabling back-to-back ops).
module alu_iterative
    import alu_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       aluop,
    input  logic             rf_en,
    input  logic [4:0]       rd,
    input  logic [XLEN-1:0]  opa,
    input  logic [XLEN-1:0]  opb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [4:0]       out_rd,
    output logic             out_we,
    output logic             busy,
    output alu_state_t       dbg_state
);

    alu_state_t        r_state;
    aluop_t            r_op;
    logic [SHAMT_W-1:0] r_cnt;
    logic [XLEN-1:0]   r_result;
    logic [4:0]        r_out_rd;
    logic              r_out_we;
    logic              r_out_valid;

    logic              w_accept;
    logic              w_is_shift;
    logic [SHAMT_W-1:0] w_shamt;
    logic [XLEN-1:0]   w_alu_result;
    logic [XLEN-1:0]   w_shift_next;

    assign in_ready   = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_is_shift = is_shift(aluop);
    assign w_shamt    = opb[SHAMT_W-1:0];

    alu_single_cycle #(.XLEN(XLEN)) u_single (
        .i_op     (aluop),
        .i_opa    (opa),
        .i_opb    (opb),
        .o_result (w_alu_result)
    );

    // While shifting, r_result doubles as the shift register; out_valid is
    // low so its intermediate values are never consumed.
    always_comb begin
        w_shift_next = r_result;
        case (r_op)
            OP_SLL:  w_shift_next = {r_result[XLEN-2:0], 1'b0};
            OP_SRL:  w_shift_next = {1'b0, r_result[XLEN-1:1]};
            OP_SRA:  w_shift_next = {r_result[XLEN-1], r_result[XLEN-1:1]};
            default: w_shift_next = r_result;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= OP_ADD;
            r_cnt       <= '0;
            r_result    <= '0;
            r_out_rd    <= '0;
            r_out_we    <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_out_rd <= rd;
                        r_out_we <= rf_en && (rd != 5'd0);
                        if (w_is_shift && (w_shamt != '0)) begin
                            r_result    <= opa;
                            r_cnt       <= w_shamt;
                            r_op        <= aluop_t'(aluop);
                            r_out_valid <= 1'b0;
                            r_state     <= S_SHIFT;
                        end else begin
                            // A zero-distance shift is just opa.
                            r_result    <= w_is_shift ? opa : w_alu_result;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end else if ((r_state == S_DONE) && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    r_result <= w_shift_next;
                    r_cnt    <= r_cnt - SHAMT_W'(1);
                    if (r_cnt == SHAMT_W'(1)) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign out_result = r_result;
    assign out_rd     = r_out_rd;
    assign out_we     = r_out_we;
    assign busy       = (r_state != S_IDLE);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_alu_iterative.sv
// Bench for alu_iterative: directed cases plus randomized ops checked
// against an arithmetic reference model and an expected-result queue.
module tb_alu_iterative;
    import alu_pkg::*;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       aluop = 4'd0;
    logic             rf_en = 1'b0;
    logic [4:0]       rd = 5'd0;
    logic [W-1:0]     opa = '0;
    logic [W-1:0]     opb = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     out_result;
    logic [4:0]       out_rd;
    logic             out_we;
    logic             busy;
    alu_state_t       dbg_state;

    alu_iterative #(.XLEN(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .aluop      (aluop),
        .rf_en      (rf_en),
        .rd         (rd),
        .opa        (opa),
        .opb        (opb),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_we     (out_we),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];
    logic [4:0]   rd_q[$];
    logic         we_q[$];
    int           lat_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: the instruction semantics written as plain arithmetic.
    function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        int sh;
        sh = int'(b % W);
        case (op)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0011: return (int'($signed(a)) < int'($signed(b))) ? 1 : 0;
            4'b0100: return (longint'(a) < longint'(b)) ? 1 : 0;
            4'b0101: return a ^ b;
            4'b0110: return W'(longint'(a) * (longint'(1) << sh));
            4'b0111: return W'(longint'(a) / (longint'(1) << sh));
            4'b1000: return W'(($signed(longint'(int'($signed(a))))) >>> sh);
            4'b1001: return a | b;
            4'b1010: return a & b;
            default: return '0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input logic [W-1:0] b);
        if ((op == 4'b0110 || op == 4'b0111 || op == 4'b1000) && (b % W) != 0)
            return int'(b % W) + 1;
        return 1;
    endfunction

    // ---------------- driver tasks ----------------
    // Present one op at a negedge once in_ready is high; it is accepted on
    // the next posedge. Returns at the negedge after acceptance.
    task automatic issue_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [4:0] d, input logic en);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("in_ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        aluop = op; opa = a; opb = b; rd = d; rf_en = en;
        exp_q.push_back(ref_alu(op, a, b));
        rd_q.push_back(d);
        we_q.push_back(en && (d != 5'd0));
        lat_q.push_back(ref_latency(op, b));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called at the negedge after acceptance; waits for out_valid and
    // checks result, rd, we, latency and that no op was accepted meanwhile.
    task automatic wait_result(input string tag);
        int lat;
        logic rdy_seen;
        lat = 1;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_ready_low_while_busy"}, 64'(rdy_seen), 64'd0);
        if (exp_q.size() > 0) begin
            check({tag, "_result"}, 64'(out_result), 64'(exp_q.pop_front()));
            check({tag, "_rd"}, 64'(out_rd), 64'(rd_q.pop_front()));
            check({tag, "_we"}, 64'(out_we), 64'(we_q.pop_front()));
            check({tag, "_latency"}, 64'(lat), 64'(lat_q.pop_front()));
        end else begin
            check({tag, "_queue_empty"}, 64'd0, 64'd1);
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [4:0] d, input logic en);
        issue_op(op, a, b, d, en);
        wait_result(tag);
        release_result();
    endtask

    logic [3:0] op_tab [12];

    // ---------------- main sequence ----------------
    initial begin
        op_tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101, 4'b0110,
                   4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b0010, 4'b1111};

        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_rd", 64'(out_rd), 64'd0);
        check("rst_out_we", 64'(out_we), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'd1);

        // Directed cases
        run_op("add", 4'b0000, 32'd5, 32'd7, 5'd3, 1'b1);
        check("add_value_const", 64'(out_result), 64'd12);
        check("idle_after_release", 64'(busy), 64'd0);
        run_op("sub", 4'b0001, 32'd3, 32'd5, 5'd4, 1'b1);
        check("sub_value_const", 64'(out_result), 64'hFFFF_FFFE);
        run_op("slt", 4'b0011, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1);
        run_op("sltu", 4'b0100, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1);
        run_op("xor", 4'b0101, 32'h0000_F0F0, 32'h0000_0FF0, 5'd6, 1'b1);
        run_op("sll31", 4'b0110, 32'd1, 32'd31, 5'd7, 1'b1);
        check("sll31_value_const", 64'(out_result), 64'h8000_0000);
        run_op("sra4", 4'b1000, 32'h8000_0000, 32'd4, 5'd8, 1'b1);
        check("sra4_value_const", 64'(out_result), 64'hF800_0000);
        run_op("srl4", 4'b0111, 32'h8000_0000, 32'd4, 5'd8, 1'b1);
        check("srl4_value_const", 64'(out_result), 64'h0800_0000);
        run_op("sll0", 4'b0110, 32'hDEAD_BEEF, 32'h0000_0020, 5'd9, 1'b1);
        run_op("rd0", 4'b0000, 32'd1, 32'd2, 5'd0, 1'b1);
        run_op("undef", 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 5'd10, 1'b1);
        run_op("rfen0", 4'b1001, 32'h00FF_0000, 32'h0000_00FF, 5'd11, 1'b0);

        // Backpressure then back-to-back handoff
        issue_op(4'b0000, 32'd10, 32'd20, 5'd12, 1'b1);
        wait_result("bp_first");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_result", 64'(out_result), 64'd30);
            check("bp_hold_rd", 64'(out_rd), 64'd12);
            check("bp_hold_in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b1;
        aluop = 4'b0000; opa = 32'd100; opb = 32'd23; rd = 5'd13; rf_en = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back(ref_alu(4'b0000, 32'd100, 32'd23));
        rd_q.push_back(5'd13);
        we_q.push_back(1'b1);
        lat_q.push_back(1);
        #1 check("b2b_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        wait_result("b2b_second");
        release_result();

        // Reset in the middle of a shift
        issue_op(4'b0110, 32'd3, 32'd20, 5'd14, 1'b1);
        repeat (9) @(negedge clk);
        check("midshift_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("midshift_rst_valid", 64'(out_valid), 64'd0);
        check("midshift_rst_busy", 64'(busy), 64'd0);
        check("midshift_rst_result", 64'(out_result), 64'd0);
        exp_q.delete(); rd_q.delete(); we_q.delete(); lat_q.delete();
        @(negedge clk);
        rst = 1'b0;
        run_op("post_rst_add", 4'b0000, 32'd40, 32'd2, 5'd15, 1'b1);

        // Randomized ops
        for (int n = 0; n < 40; n++) begin
            logic [3:0] op;
            logic [W-1:0] a, b;
            op = op_tab[$urandom_range(0, 11)];
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = W'($urandom_range(0, 3));
            run_op("rand", op, a, b, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
